ps2_scancode_rx: RTL



---
 rtl/ps2_pkg.sv | 10 +
 rtl/ps2_scancode_rx_if.sv | 10 +
 rtl/ps2_frame_rx.sv | 112 +++++++++++
 rtl/ps2_scancode_rx.sv | 86 ++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared scan-code constants, frame length and FSM state types for the PS/2 receiver.
package ps2_pkg;
    localparam int FRAME_BITS = 11;
    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_ENTER     = 8'h5A;
    localparam logic [7:0] SC_BACKSLASH = 8'h5D;
    typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
    typedef enum logic [1:0] {D_NORMAL, D_EXT, D_BREAK, D_EXT_BREAK} dec_state_t;
endpackage

// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if: scan-code bus from the PS/2 front end to the game controller.
interface ps2_scancode_rx_if;
    logic [7:0] scancode;
    logic       code_valid;
    logic       key_released;
    logic       extended;
    logic       frame_err;
    modport master (output scancode, code_valid, key_released, extended, frame_err);
    modport slave  (input  scancode, code_valid, key_released, extended, frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 line sync, clock de-glitch, 11-bit frame deserialiser with timeout.
// Odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
`ifdef PS2_PARITY_CHECK_EN
    localparam bit CHECK_PAR = 1'b1;
`else
    localparam bit CHECK_PAR = 1'b0;
`endif
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] F_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] cs, ds;
    logic [FW-1:0] fcnt;
    logic          filt;
    logic          clk_s, data_s, strobe, ok;
    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmo;

    assign clk_s  = cs[SYNC_STAGES-1];
    assign data_s = ds[SYNC_STAGES-1];
    // strobe marks the cycle the filtered clock commits a 1->0 change
    assign strobe = filt & ~clk_s & (fcnt == F_MAX);
    assign ok     = data_s & (CHECK_PAR ? ^{shreg, par} : 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs   <= '1;
            ds   <= '1;
            filt <= 1'b1;
            fcnt <= '0;
        end else begin
            cs <= {cs[SYNC_STAGES-2:0], PS2Clk};
            ds <= {ds[SYNC_STAGES-2:0], PS2Data};
            if (clk_s == filt) begin
                fcnt <= '0;
            end else if (fcnt == F_MAX) begin
                filt <= clk_s;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= F_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tmo        <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            tmo        <= (strobe || state == F_IDLE) ? '0 : tmo + 1'b1;
            if (strobe) begin
                unique case (state)
                    F_IDLE: begin
                        if (data_s) frame_err <= 1'b1;
                        else begin
                            state   <= F_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    F_DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= F_PARITY;
                    end
                    F_PARITY: begin
                        par   <= data_s;
                        state <= F_STOP;
                    end
                    F_STOP: begin
                        state <= F_IDLE;
                        if (ok) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end else if (state != F_IDLE && tmo == T_MAX) begin
                frame_err <= 1'b1;
                state     <= F_IDLE;
            end
        end
    end
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard front end holding the current make code until its break arrives.
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      PS2Clk,
    input  logic                      PS2Data,
    ps2_scancode_rx_if.master         bus
);
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic [7:0] scancode;
    logic       code_valid, key_released, extended;
    dec_state_t dstate;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .PS2Clk    (PS2Clk),
        .PS2Data   (PS2Data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate       <= D_NORMAL;
            scancode     <= '0;
            extended     <= 1'b0;
            code_valid   <= 1'b0;
            key_released <= 1'b0;
        end else begin
            code_valid   <= 1'b0;
            key_released <= 1'b0;
            if (byte_valid) begin
                unique case (dstate)
                    D_NORMAL: begin
                        if (byte_data == SC_EXT) dstate <= D_EXT;
                        else if (byte_data == SC_BREAK) dstate <= D_BREAK;
                        else begin
                            scancode   <= byte_data;
                            extended   <= 1'b0;
                            code_valid <= 1'b1;
                        end
                    end
                    D_EXT: begin
                        if (byte_data == SC_BREAK) dstate <= D_EXT_BREAK;
                        else begin
                            scancode   <= byte_data;
                            extended   <= 1'b1;
                            code_valid <= 1'b1;
                            dstate     <= D_NORMAL;
                        end
                    end
                    D_BREAK, D_EXT_BREAK: begin
                        // releasing an older key must not clear a newer held one
                        key_released <= 1'b1;
                        dstate       <= D_NORMAL;
                        if (byte_data == scancode) begin
                            scancode <= '0;
                            extended <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.scancode     = scancode;
    assign bus.code_valid   = code_valid;
    assign bus.key_released = key_released;
    assign bus.extended     = extended;
    assign bus.frame_err    = frame_err;
endmodule
